// File: rtl/pe83_priority_encoder.sv
// pe83_priority_encoder
// Registered 8-to-3 priority encoder. Bit 7 of the request vector wins over
// every lower bit. The registered outputs are the index of the winning bit, a
// valid flag that says whether any request was present, and the one-hot form
// of the grant. Downstream logic must qualify the index with valid, because
// index 0 is reported both for "no request" and for "only bit 0 requested".
module pe83_priority_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] D,
    output logic [2:0] Y,
    output logic       valid,
    output logic [7:0] onehot
);

    logic [2:0] y_next;
    logic       valid_next;
    logic [7:0] onehot_next;

    // Combinational encode. The loop runs from bit 0 upward, so a higher set
    // bit overwrites whatever a lower one wrote and the highest set bit decides
    // the result. With no bit set, the defaults give index 0, valid low and an
    // all-zero one-hot vector.
    always_comb begin
        y_next      = 3'b000;
        valid_next  = 1'b0;
        onehot_next = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (D[i]) begin
                y_next      = 3'(i);
                valid_next  = 1'b1;
                onehot_next = 8'h01 << i;
            end
        end
    end

    // Output registers. Reset takes priority over the enable. When the enable
    // is low, the last encoded result is held and D is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            Y      <= 3'b000;
            valid  <= 1'b0;
            onehot <= 8'h00;
        end else if (en) begin
            Y      <= y_next;
            valid  <= valid_next;
            onehot <= onehot_next;
        end
    end

endmodule

// File: tb/tb_pe83_priority_encoder.sv
// tb_pe83_priority_encoder
// Directed bench for the registered 8-to-3 priority encoder. Inputs change 1ns
// after a rising edge. Outputs are sampled 1ns after the next rising edge, when
// the registers have already taken the value that was applied.
module tb_pe83_priority_encoder;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] D;
    logic [2:0] Y;
    logic       valid;
    logic [7:0] onehot;

    int total_count = 0;
    int bad_count   = 0;

    pe83_priority_encoder dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .D      (D),
        .Y      (Y),
        .valid  (valid),
        .onehot (onehot)
    );

    // 10ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value, count the comparison,
    // and report a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_count++;
        if (got !== exp) begin
            bad_count++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h (D=0x%02h en=%0b rst=%0b)",
                     tag, got, exp, D, en, rst);
        end
    endtask

    // Drive the inputs, then advance past one rising edge
    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] d);
        rst = r;
        en  = e;
        D   = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: scan from the top bit down and stop at the first set bit.
    // The result is packed as {valid, Y, onehot}.
    function automatic logic [11:0] refEncode(input logic [7:0] d);
        logic [11:0] r;
        logic        found;
        r     = 12'h000;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found && d[i]) begin
                found    = 1'b1;
                r[11]    = 1'b1;
                r[10:8]  = 3'(i);
                r[7:0]   = 8'h00;
                r[i]     = 1'b1;
            end
        end
        return r;
    endfunction

    // Check the three invariants that must hold on every cycle after reset
    task automatic checkInvariants(input string tag);
        checkOutput({tag, "_onehot_le1"}, 32'($countones(onehot) <= 1), 32'd1);
        checkOutput({tag, "_valid_or"}, 32'(valid), 32'(|onehot));
        if (valid)
            checkOutput({tag, "_onehot_at_y"}, 32'(onehot[Y]), 32'd1);
    endtask

    // Check all outputs against explicit expected values
    task automatic checkAll(input string tag, input logic [2:0] ey, input logic ev, input logic [7:0] eo);
        checkOutput({tag, "_Y"}, 32'(Y), 32'(ey));
        checkOutput({tag, "_valid"}, 32'(valid), 32'(ev));
        checkOutput({tag, "_onehot"}, 32'(onehot), 32'(eo));
    endtask

    logic [7:0]  multi_d  [5] = '{8'b10101010, 8'b01010101, 8'b00110011, 8'b11001100, 8'b00010001};
    logic [2:0]  multi_y  [5] = '{3'd7, 3'd6, 3'd5, 3'd7, 3'd4};
    logic [7:0]  multi_oh [5] = '{8'h80, 8'h40, 8'h20, 8'h80, 8'h10};

    // Main stimulus sequence
    initial begin
        logic [11:0] exp_r;
        logic [7:0]  d_byte;
        rst = 1'b1;
        en  = 1'b1;
        D   = 8'hFF;

        // Reset for two cycles while D is all ones and en is high
        applyStimulus(1'b1, 1'b1, 8'hFF);
        checkAll("reset1", 3'd0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        checkAll("reset2", 3'd0, 1'b0, 8'h00);

        // Release reset with no request
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkAll("release", 3'd0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkAll("no_req", 3'd0, 1'b0, 8'h00);
        checkInvariants("no_req");

        // Walk a single set bit from bit 0 up to bit 7
        for (int i = 0; i < 8; i++) begin
            d_byte = 8'h01 << i;
            applyStimulus(1'b0, 1'b1, d_byte);
            checkAll($sformatf("walk%0d", i), 3'(i), 1'b1, d_byte);
            checkInvariants($sformatf("walk%0d", i));
        end

        // Several bits set at once
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, multi_d[i]);
            checkAll($sformatf("multi%0d", i), multi_y[i], 1'b1, multi_oh[i]);
            checkInvariants($sformatf("multi%0d", i));
        end

        // Enable hold: load index 4, then hold it while D changes
        applyStimulus(1'b0, 1'b1, 8'h10);
        checkAll("hold_load", 3'd4, 1'b1, 8'h10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h81);
            checkAll($sformatf("hold%0d", i), 3'd4, 1'b1, 8'h10);
        end
        applyStimulus(1'b0, 1'b1, 8'h81);
        checkAll("hold_release", 3'd7, 1'b1, 8'h80);

        // Reset mid-run overrides en and D
        applyStimulus(1'b1, 1'b1, 8'h40);
        checkAll("reset_mid", 3'd0, 1'b0, 8'h00);

        // Sweep all 256 request values against the reference model
        for (int v = 0; v < 256; v++) begin
            applyStimulus(1'b0, 1'b1, 8'(v));
            exp_r = refEncode(8'(v));
            checkAll($sformatf("sweep%0d", v), exp_r[10:8], exp_r[11], exp_r[7:0]);
            checkInvariants($sformatf("sweep%0d", v));
        end

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/pe83_priority_encoder.md
Name: pe83_priority_encoder

Overview:
- Registered 8-to-3 priority encoder used wherever one of eight request lines must be reduced to a binary index.
- Bit D[7] has highest priority; D[0] has lowest.
- Outputs are the 3-bit index of the highest set input bit, plus a valid flag that is high when any input bit is set.
- Single clock domain, with a synchronous active-high reset.

Parameters:
- none (widths fixed: 8-bit input, 3-bit index)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  update enable; when low, outputs hold their last value
- D  input  8  request vector; bit i set = request i active
- Y  output  3  index of highest-priority active bit (registered)
- valid  output  1  high when the sampled D was non-zero (registered)
- onehot  output  8  one-hot form of the granted bit; all-zero when none active (registered)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, set Y=3'b000, valid=0, onehot=8'h00. Reset overrides en and D.
- Encode function (combinational core): scan from bit 7 down to bit 0. The first bit found set gives the index i:
  - Y_next = i
  - valid_next = 1
  - onehot_next = 1<<i
- D = 8'h00 gives Y_next=3'b000, valid_next=0, onehot_next=8'h00.
  - Y=0 with valid=0 is distinct from "bit 0 active", which is Y=0 with valid=1. Consumers must qualify Y with valid.
- Latency: on a rising edge with rst=0 and en=1, the Y, valid and onehot registers load the encode of D. Outputs therefore reflect D sampled one cycle earlier.
- en=0 (rst=0): all output registers hold. D changes are ignored.
- Multiple active bits: only the highest-index set bit is reported. Lower bits are don't-care and do not change Y.
- Invariants, every cycle after reset:
  - onehot has at most one bit set.
  - valid == |onehot.
  - When valid=1, onehot[Y]=1.
- No X propagation from unused states: outputs are fully defined for all 256 values of D.
- Changing D between edges has no effect on outputs until the next enabled edge.
- Inputs assumed synchronous to clk; no internal synchronizers.

Test Plan:
- Reset: assert rst for 2 cycles with D=8'hFF and en=1 -> Y=0, valid=0, onehot=8'h00. Deassert rst with D=8'h00 -> outputs stay Y=0, valid=0.
- No request: D=8'h00, en=1 -> after one edge Y=0, valid=0, onehot=8'h00.
- Single active bit: walk D through 8'h01, 02, 04, 08, 10, 20, 40, 80, one per cycle.
  - Required Y (one cycle later): 0, 1, 2, 3, 4, 5, 6, 7.
  - valid=1 throughout; onehot equals D.
- Multiple active bits, one cycle latency each:
  - D=8'b10101010 -> Y=7
  - D=8'b01010101 -> Y=6
  - D=8'b00110011 -> Y=5
  - D=8'b11001100 -> Y=7
  - D=8'b00010001 -> Y=4
  - valid=1 for all five; onehot = 8'h80, 40, 20, 80, 10 respectively.
- Enable hold: load D=8'h10 with en=1 (Y=4). Then set en=0 and D=8'h81 for 3 cycles -> Y=4, valid=1 held. Raise en -> next edge Y=7, onehot=8'h80.
- Exhaustive: sweep D over all 256 values with en=1 and compare each output against a reference model one cycle later. Check the onehot/valid/Y invariants on every cycle.
